// File: rtl/frame_fifo_if.sv
// frame_fifo_if: write stream, read stream and status bundle of frame_fifo.
interface frame_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 11,
    parameter int FRAME_AW   = 4
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_err;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic [LEN_WIDTH-1:0]  rd_len;
    logic [FRAME_AW:0]     frame_count;
    logic [ADDR_WIDTH:0]   free_words;
    logic                  drop_pulse;
    logic                  drop_ovf;

    modport master (
        output wr_valid, wr_data, wr_last, wr_err, rd_ready,
        input  rd_valid, rd_data, rd_last, rd_len, frame_count, free_words, drop_pulse, drop_ovf
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, wr_err, rd_ready,
        output rd_valid, rd_data, rd_last, rd_len, frame_count, free_words, drop_pulse, drop_ovf
    );
endinterface

// File: rtl/frame_fifo.sv
// frame_fifo: store-and-forward frame FIFO; frames become readable only once
// fully written without error, errored/oversize/non-fitting frames are dropped whole.
module frame_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 11,
    parameter int FRAME_AW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    frame_fifo_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int FDEPTH = 2 ** FRAME_AW;

    typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [LEN_WIDTH-1:0]  desc_q [FDEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   used, free_words_q;
    logic [FRAME_AW:0]     dwr_ptr_q, drd_ptr_q, frame_count_q, frame_count_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, flen_q, flen_d, fcnt_q, fcnt_d, rd_len_q, rd_len_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic                  drop_q, drop_d, ovf_q, ovf_d;
    logic                  mem_we, push, ram_full, q_full, ovf_drop, err_drop;
    logic                  busy, start, fetch, xfer;

    // Queue fullness counts frames until fully read, so a prefetched head still occupies its slot.
    assign used     = wr_ptr_q - rd_ptr_q;
    assign ram_full = used[ADDR_WIDTH];
    assign q_full   = frame_count_q[FRAME_AW];
    assign ovf_drop = ram_full || ((state_q == IDLE) ? q_full : &len_q);
    assign err_drop = bus.wr_last && bus.wr_err;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        len_d       = len_q;
        mem_we      = 1'b0;
        push        = 1'b0;
        drop_d      = 1'b0;
        ovf_d       = 1'b0;
        if (bus.wr_valid && state_q != DISCARD) begin
            if (ovf_drop || err_drop) begin
                drop_d   = 1'b1;
                ovf_d    = ovf_drop;
                wr_ptr_d = wr_commit_q;
                state_d  = bus.wr_last ? IDLE : DISCARD;
            end else begin
                mem_we      = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                len_d       = (state_q == IDLE) ? LEN_WIDTH'(1) : len_q + 1'b1;
                push        = bus.wr_last;
                wr_commit_d = bus.wr_last ? wr_ptr_d : wr_commit_q;
                state_d     = bus.wr_last ? IDLE : WRITE;
            end
        end else if (bus.wr_valid && bus.wr_last) begin
            state_d = IDLE;
        end
    end

    // Fetch side refills the output register; it moves to the next committed frame with no bubble.
    assign busy  = fcnt_q != flen_q;
    assign start = !busy && (dwr_ptr_q != drd_ptr_q);
    assign fetch = (!rd_valid_q || bus.rd_ready) && (busy || start);
    assign xfer  = rd_valid_q && bus.rd_ready;

    always_comb begin
        flen_d        = (fetch && start) ? desc_q[drd_ptr_q[FRAME_AW-1:0]] : flen_q;
        fcnt_d        = fetch ? (start ? LEN_WIDTH'(1) : fcnt_q + 1'b1) : fcnt_q;
        rd_ptr_d      = rd_ptr_q + (ADDR_WIDTH+1)'(fetch);
        rd_valid_d    = fetch || (rd_valid_q && !bus.rd_ready);
        rd_data_d     = fetch ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : rd_data_q;
        rd_last_d     = fetch ? (fcnt_d == flen_d) : rd_last_q;
        rd_len_d      = fetch ? flen_d : rd_len_q;
        frame_count_d = frame_count_q + (FRAME_AW+1)'(push) - (FRAME_AW+1)'(xfer && rd_last_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            rd_ptr_q      <= '0;
            dwr_ptr_q     <= '0;
            drd_ptr_q     <= '0;
            len_q         <= '0;
            flen_q        <= '0;
            fcnt_q        <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_last_q     <= 1'b0;
            rd_len_q      <= '0;
            frame_count_q <= '0;
            free_words_q  <= (ADDR_WIDTH+1)'(DEPTH);
            drop_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_commit_q   <= wr_commit_d;
            rd_ptr_q      <= rd_ptr_d;
            dwr_ptr_q     <= dwr_ptr_q + (FRAME_AW+1)'(push);
            drd_ptr_q     <= drd_ptr_q + (FRAME_AW+1)'(fetch && start);
            len_q         <= len_d;
            flen_q        <= flen_d;
            fcnt_q        <= fcnt_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            rd_last_q     <= rd_last_d;
            rd_len_q      <= rd_len_d;
            frame_count_q <= frame_count_d;
            free_words_q  <= (ADDR_WIDTH+1)'(DEPTH) - (wr_ptr_d - rd_ptr_d);
            drop_q        <= drop_d;
            ovf_q         <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
        if (push) desc_q[dwr_ptr_q[FRAME_AW-1:0]] <= len_d;
    end

    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_last     = rd_last_q;
    assign bus.rd_len      = rd_len_q;
    assign bus.frame_count = frame_count_q;
    assign bus.free_words  = free_words_q;
    assign bus.drop_pulse  = drop_q;
    assign bus.drop_ovf    = ovf_q;
endmodule

// File: tb/tb_frame_fifo.sv
// tb_frame_fifo: directed checks of frame_fifo at default, small-RAM and small-queue sizes.
module tb_frame_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_last = 1'b0;
    logic       wr_err = 1'b0;
    logic       rd_ready = 1'b0;
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    frame_fifo_if b0 ();
    frame_fifo_if #(.ADDR_WIDTH(4)) b1 ();
    frame_fifo_if #(.FRAME_AW(2)) b2 ();

    frame_fifo d0 (.clk(clk), .rst(rst), .bus(b0));
    frame_fifo #(.ADDR_WIDTH(4)) d1 (.clk(clk), .rst(rst), .bus(b1));
    frame_fifo #(.FRAME_AW(2)) d2 (.clk(clk), .rst(rst), .bus(b2));

    assign b0.wr_valid = wr_valid;
    assign b0.wr_data  = wr_data;
    assign b0.wr_last  = wr_last;
    assign b0.wr_err   = wr_err;
    assign b0.rd_ready = rd_ready;
    assign b1.wr_valid = wr_valid;
    assign b1.wr_data  = wr_data;
    assign b1.wr_last  = wr_last;
    assign b1.wr_err   = wr_err;
    assign b1.rd_ready = rd_ready;
    assign b2.wr_valid = wr_valid;
    assign b2.wr_data  = wr_data;
    assign b2.wr_last  = wr_last;
    assign b2.wr_err   = wr_err;
    assign b2.rd_ready = rd_ready;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_valid = 1'b0;
        wr_last = 1'b0;
        wr_err = 1'b0;
        rd_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic l, input logic e);
        wr_valid = 1'b1;
        wr_data = d;
        wr_last = l;
        wr_err = e;
        step();
        wr_valid = 1'b0;
        wr_last = 1'b0;
        wr_err = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rd_valid"}, 32'(b0.rd_valid), 0);
        chk({tag, " rd_last"}, 32'(b0.rd_last), 0);
        chk({tag, " rd_data"}, 32'(b0.rd_data), 0);
        chk({tag, " rd_len"}, 32'(b0.rd_len), 0);
        chk({tag, " frame_count"}, 32'(b0.frame_count), 0);
        chk({tag, " free_words"}, 32'(b0.free_words), 256);
        chk({tag, " drop_pulse"}, 32'(b0.drop_pulse), 0);
        chk({tag, " drop_ovf"}, 32'(b0.drop_ovf), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_d [7] = '{8'h61, 8'h62, 8'h63, 8'h71, 8'h72, 8'h73, 8'h74};
        logic [3:0] exp_l [7] = '{4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4};
        int drops = 0;
        logic ovf_seen = 1'b0;
        int idx = 0;

        // reset state
        step();
        do_reset();
        chk_reset_outputs("reset");

        // single 5-beat frame
        rd_ready = 1'b1;
        for (int i = 1; i <= 5; i++) beat(8'(i), i == 5, 1'b0);
        chk("t1 count after commit", 32'(b0.frame_count), 1);
        chk("t1 valid at N+1", 32'(b0.rd_valid), 0);
        chk("t1 free after commit", 32'(b0.free_words), 251);
        step();
        for (int i = 1; i <= 5; i++) begin
            chk("t1 valid", 32'(b0.rd_valid), 1);
            chk("t1 data", 32'(b0.rd_data), 32'(i));
            chk("t1 last", 32'(b0.rd_last), 32'(i == 5));
            chk("t1 len", 32'(b0.rd_len), 5);
            step();
        end
        chk("t1 valid after", 32'(b0.rd_valid), 0);
        chk("t1 count after", 32'(b0.frame_count), 0);

        // errored 10-beat frame
        for (int i = 0; i < 10; i++) beat(8'h10 + 8'(i), i == 9, i == 9);
        chk("t2 drop_pulse", 32'(b0.drop_pulse), 1);
        chk("t2 drop_ovf", 32'(b0.drop_ovf), 0);
        chk("t2 count", 32'(b0.frame_count), 0);
        chk("t2 free", 32'(b0.free_words), 256);
        step();
        chk("t2 pulse width", 32'(b0.drop_pulse), 0);
        chk("t2 valid", 32'(b0.rd_valid), 0);

        // 16-beat RAM: 12-beat frame fits, following 10-beat frame overflows
        do_reset();
        for (int i = 0; i < 12; i++) beat(8'h20 + 8'(i), i == 11, 1'b0);
        for (int i = 0; i < 10; i++) begin
            beat(8'h40 + 8'(i), i == 9, 1'b0);
            if (b1.drop_pulse) begin
                drops++;
                ovf_seen = b1.drop_ovf;
            end
        end
        step();
        chk("t3 drop count", 32'(drops), 1);
        chk("t3 drop_ovf", 32'(ovf_seen), 1);
        chk("t3 count", 32'(b1.frame_count), 1);
        chk("t3 free", 32'(b1.free_words), 5);
        chk("t3 held valid", 32'(b1.rd_valid), 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("t3 data", 32'(b1.rd_data), 32'h20 + 32'(i));
            chk("t3 len", 32'(b1.rd_len), 12);
            chk("t3 last", 32'(b1.rd_last), 32'(i == 11));
            step();
        end
        chk("t3 valid after", 32'(b1.rd_valid), 0);
        chk("t3 count after", 32'(b1.frame_count), 0);

        // 4-entry frame queue: fifth one-beat frame dropped
        do_reset();
        for (int i = 0; i < 5; i++) beat(8'h51 + 8'(i), 1'b1, 1'b0);
        chk("t4 drop_pulse", 32'(b2.drop_pulse), 1);
        chk("t4 drop_ovf", 32'(b2.drop_ovf), 1);
        chk("t4 count", 32'(b2.frame_count), 4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4 valid", 32'(b2.rd_valid), 1);
            chk("t4 data", 32'(b2.rd_data), 32'h51 + 32'(i));
            chk("t4 last", 32'(b2.rd_last), 1);
            chk("t4 len", 32'(b2.rd_len), 1);
            step();
        end
        chk("t4 valid after", 32'(b2.rd_valid), 0);
        chk("t4 count after", 32'(b2.frame_count), 0);

        // back-to-back 3- and 4-beat frames with a stalling reader
        do_reset();
        for (int i = 0; i < 3; i++) beat(8'h61 + 8'(i), i == 2, 1'b0);
        for (int i = 0; i < 4; i++) beat(8'h71 + 8'(i), i == 3, 1'b0);
        step();
        for (int k = 0; k < 20 && idx < 7; k++) begin
            rd_ready = (k % 2) == 0;
            chk("t5 valid", 32'(b0.rd_valid), 1);
            chk("t5 data", 32'(b0.rd_data), 32'(exp_d[idx]));
            chk("t5 len", 32'(b0.rd_len), 32'(exp_l[idx]));
            chk("t5 last", 32'(b0.rd_last), 32'(idx == 2 || idx == 6));
            step();
            if (rd_ready) idx++;
        end
        rd_ready = 1'b0;
        chk("t5 beats read", 32'(idx), 7);
        chk("t5 valid after", 32'(b0.rd_valid), 0);
        chk("t5 count after", 32'(b0.frame_count), 0);

        // reset during the second of three frames
        do_reset();
        beat(8'h81, 1'b0, 1'b0);
        beat(8'h82, 1'b1, 1'b0);
        beat(8'h91, 1'b0, 1'b0);
        beat(8'h92, 1'b0, 1'b0);
        chk("t6 valid before reset", 32'(b0.rd_valid), 1);
        do_reset();
        chk_reset_outputs("t6 midframe reset");
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) beat(8'hA1 + 8'(i), i == 2, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t6 data", 32'(b0.rd_data), 32'hA1 + 32'(i));
            chk("t6 len", 32'(b0.rd_len), 3);
            step();
        end
        chk("t6 count after", 32'(b0.frame_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
